// File: rtl/elevador_planta_3pisos_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : elevador_pkg
//  Brief    : Shared constants and types for the 3-floor elevator plant
//             (floor codes and motor-command encoding).
//  Revision : 1.0  initial release
// ============================================================================
package elevador_pkg;

  // BCD floor codes reported on floor_code
  localparam logic [1:0] PISO1 = 2'b01;
  localparam logic [1:0] PISO2 = 2'b10;
  localparam logic [1:0] PISO3 = 2'b11;
  localparam logic [1:0] ENTRE = 2'b00;

  // Motor command as seen on {mup, mdw}
  typedef enum logic [1:0] {
    CMD_STOP     = 2'b00,
    CMD_DOWN     = 2'b01,
    CMD_UP       = 2'b10,
    CMD_CONFLICT = 2'b11
  } motor_cmd_e;

endpackage : elevador_pkg
`default_nettype wire

// File: rtl/elevador_planta_3pisos_motor_step_gen.sv
`default_nettype none
// ============================================================================
//  Module   : motor_step_gen
//  Brief    : Turns the controller's mup/mdw motor command into a one-cycle
//             step pulse every STEP_DIV cycles of a constant command, plus a
//             direction bit. Any change of command restarts the interval.
//  Revision : 1.0  initial release
// ============================================================================
module motor_step_gen
  import elevador_pkg::*;
#(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic mup,
  input  logic mdw,
  output logic step,
  output logic step_up
);

  localparam int PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRESC_W-1:0] c_presc_last = PRESC_W'(STEP_DIV - 1);

  motor_cmd_e           cmd;
  motor_cmd_e           cmd_q;
  motor_cmd_e           cmd_d;
  logic [PRESC_W-1:0]   presc_q;
  logic [PRESC_W-1:0]   presc_d;
  logic [PRESC_W-1:0]   cnt_eff;

  // Command/prescaler registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q   <= CMD_STOP;
      presc_q <= '0;
    end else begin
      cmd_q   <= cmd_d;
      presc_q <= presc_d;
    end
  end

  // Decode the command, restart the interval on a change, and fire the step
  always_comb begin
    cmd     = motor_cmd_e'({mup, mdw});
    cmd_d   = cmd;
    cnt_eff = (cmd != cmd_q) ? '0 : presc_q;
    presc_d = '0;
    step    = 1'b0;
    step_up = (cmd == CMD_UP);
    unique case (cmd)
      CMD_UP, CMD_DOWN: begin
        if (cnt_eff == c_presc_last) begin
          step    = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = cnt_eff + 1'b1;
        end
      end
      CMD_STOP, CMD_CONFLICT: begin
        presc_d = '0;
      end
      default: begin
        presc_d = '0;
      end
    endcase
  end

endmodule : motor_step_gen
`default_nettype wire

// File: rtl/elevador_planta_3pisos.sv
`default_nettype none
// ============================================================================
//  Module   : elevador_planta_3pisos
//  Brief    : Behavioural car + shaft for the 3-floor elevator. Integrates
//             motor steps into a saturating car position and drives the
//             floor-limit sensors, floor code and status flags.
//  Revision : 1.0  initial release
// ============================================================================
module elevador_planta_3pisos
  import elevador_pkg::*;
#(
  parameter int TICKS_PER_FLOOR = 16,
  parameter int STEP_DIV        = 4,
  parameter int START_FLOOR     = 1,
  localparam int POS_W          = $clog2(2 * TICKS_PER_FLOOR + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mup,
  input  logic             mdw,
  output logic             f1,
  output logic             f2,
  output logic             f3,
  output logic [POS_W-1:0] pos,
  output logic [1:0]       floor_code,
  output logic             moving,
  output logic             conflict,
  output logic             overtravel
);

  localparam logic [POS_W-1:0] c_pos_f2    = POS_W'(TICKS_PER_FLOOR);
  localparam logic [POS_W-1:0] c_pos_max   = POS_W'(2 * TICKS_PER_FLOOR);
  localparam logic [POS_W-1:0] c_start_pos = POS_W'((START_FLOOR - 1) * TICKS_PER_FLOOR);

  logic             step;
  logic             step_up;
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_d;
  logic             overtravel_q;
  logic             overtravel_d;

  motor_step_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_step_gen (
    .clk     (clk),
    .reset   (reset),
    .mup     (mup),
    .mdw     (mdw),
    .step    (step),
    .step_up (step_up)
  );

  // Position and sticky overtravel registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q        <= c_start_pos;
      overtravel_q <= 1'b0;
    end else begin
      pos_q        <= pos_d;
      overtravel_q <= overtravel_d;
    end
  end

  // Apply a step with saturation at both shaft ends; blocked steps flag overtravel
  always_comb begin
    pos_d        = pos_q;
    overtravel_d = overtravel_q;
    if (step) begin
      if (step_up) begin
        if (pos_q == c_pos_max) begin
          overtravel_d = 1'b1;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end else begin
        if (pos_q == '0) begin
          overtravel_d = 1'b1;
        end else begin
          pos_d = pos_q - 1'b1;
        end
      end
    end
  end

  // Sensor and status decode from the registered position and live command
  always_comb begin
    f1         = (pos_q == '0);
    f2         = (pos_q == c_pos_f2);
    f3         = (pos_q == c_pos_max);
    floor_code = ENTRE;
    if (f1) floor_code = PISO1;
    if (f2) floor_code = PISO2;
    if (f3) floor_code = PISO3;
    moving     = mup ^ mdw;
    conflict   = mup & mdw;
    pos        = pos_q;
    overtravel = overtravel_q;
  end

endmodule : elevador_planta_3pisos
`default_nettype wire

// File: tb/tb_elevador_planta_3pisos.sv
`default_nettype none
// ============================================================================
//  Module   : tb_elevador_planta_3pisos
//  Brief    : Directed, table-driven bench for the elevator plant: a default
//             instance walked through the shaft, plus a short-shaft
//             STEP_DIV=1, START_FLOOR=3 instance for the fast-step corner.
//  Revision : 1.0  initial release
// ============================================================================
module tb_elevador_planta_3pisos;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic       reset_a, mup_a, mdw_a;
  logic       f1_a, f2_a, f3_a, mv_a, cf_a, ot_a;
  logic [5:0] pos_a;
  logic [1:0] code_a;

  // Short shaft, one step per cycle, starts at floor 3
  logic       reset_b, mup_b, mdw_b;
  logic       f1_b, f2_b, f3_b, mv_b, cf_b, ot_b;
  logic [3:0] pos_b;
  logic [1:0] code_b;

  elevador_planta_3pisos u_dut_a (
    .clk        (clk),
    .reset      (reset_a),
    .mup        (mup_a),
    .mdw        (mdw_a),
    .f1         (f1_a),
    .f2         (f2_a),
    .f3         (f3_a),
    .pos        (pos_a),
    .floor_code (code_a),
    .moving     (mv_a),
    .conflict   (cf_a),
    .overtravel (ot_a)
  );

  elevador_planta_3pisos #(
    .TICKS_PER_FLOOR (4),
    .STEP_DIV        (1),
    .START_FLOOR     (3)
  ) u_dut_b (
    .clk        (clk),
    .reset      (reset_b),
    .mup        (mup_b),
    .mdw        (mdw_b),
    .f1         (f1_b),
    .f2         (f2_b),
    .f3         (f3_b),
    .pos        (pos_b),
    .floor_code (code_b),
    .moving     (mv_b),
    .conflict   (cf_b),
    .overtravel (ot_b)
  );

  typedef struct {
    logic       rst;
    logic       up;
    logic       dn;
    int         n;
    int         pos;
    logic [2:0] f;
    logic [1:0] code;
    logic       mv;
    logic       cf;
    logic       ot;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic rst, logic up, logic dn, int n, int p,
                              logic [2:0] f, logic [1:0] code,
                              logic mv, logic cf, logic ot);
    vec_t v;
    v.rst = rst; v.up = up; v.dn = dn; v.n = n; v.pos = p;
    v.f = f; v.code = code; v.mv = mv; v.cf = cf; v.ot = ot;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s [step %0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    // rst up dn  n   pos  f1f2f3  code  mv cf ot
    vecs[0]  = mk(0, 0, 0,  0,  0, 3'b100, 2'b01, 0, 0, 0); // reset state
    vecs[1]  = mk(0, 1, 0,  3,  0, 3'b100, 2'b01, 1, 0, 0); // no step before 4th cycle
    vecs[2]  = mk(0, 1, 0,  1,  1, 3'b000, 2'b00, 1, 0, 0); // first step
    vecs[3]  = mk(0, 1, 0, 60, 16, 3'b010, 2'b10, 1, 0, 0); // floor 2 at 64
    vecs[4]  = mk(0, 1, 0, 64, 32, 3'b001, 2'b11, 1, 0, 0); // floor 3 at 128
    vecs[5]  = mk(0, 1, 0,  4, 32, 3'b001, 2'b11, 1, 0, 1); // blocked above
    vecs[6]  = mk(0, 0, 0,  1, 32, 3'b001, 2'b11, 0, 0, 1); // sticky
    vecs[7]  = mk(0, 0, 1, 64, 16, 3'b010, 2'b10, 1, 0, 1); // down to floor 2
    vecs[8]  = mk(1, 0, 0,  1,  0, 3'b100, 2'b01, 0, 0, 0); // reset
    vecs[9]  = mk(0, 1, 0, 64, 16, 3'b010, 2'b10, 1, 0, 0);
    vecs[10] = mk(0, 1, 1, 10, 16, 3'b010, 2'b10, 0, 1, 0); // conflict holds
    vecs[11] = mk(0, 0, 1,  3, 16, 3'b010, 2'b10, 1, 0, 0);
    vecs[12] = mk(0, 0, 1,  1, 15, 3'b000, 2'b00, 1, 0, 0);
    vecs[13] = mk(0, 0, 1, 60,  0, 3'b100, 2'b01, 1, 0, 0); // exactly to floor 1
    vecs[14] = mk(0, 0, 0,  1,  0, 3'b100, 2'b01, 0, 0, 0);
    vecs[15] = mk(0, 1, 0, 10,  2, 3'b000, 2'b00, 1, 0, 0);
    vecs[16] = mk(0, 0, 1,  3,  2, 3'b000, 2'b00, 1, 0, 0); // interval restarted
    vecs[17] = mk(0, 0, 1,  1,  1, 3'b000, 2'b00, 1, 0, 0);
    vecs[18] = mk(0, 0, 1,  4,  0, 3'b100, 2'b01, 1, 0, 0);
    vecs[19] = mk(0, 0, 1,  4,  0, 3'b100, 2'b01, 1, 0, 1); // blocked below
    vecs[20] = mk(0, 1, 0, 80, 20, 3'b000, 2'b00, 1, 0, 1);
    vecs[21] = mk(1, 1, 0,  1,  0, 3'b100, 2'b01, 1, 0, 0); // reset mid-motion
    vecs[22] = mk(0, 1, 0,  3,  0, 3'b100, 2'b01, 1, 0, 0);
    vecs[23] = mk(0, 1, 0,  1,  1, 3'b000, 2'b00, 1, 0, 0);

    reset_a = 1'b1; mup_a = 1'b0; mdw_a = 1'b0;
    reset_b = 1'b1; mup_b = 1'b0; mdw_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_a = 1'b0;
    reset_b = 1'b0;

    for (int i = 0; i < NV; i++) begin
      reset_a = vecs[i].rst;
      mup_a   = vecs[i].up;
      mdw_a   = vecs[i].dn;
      repeat (vecs[i].n) @(posedge clk);
      #1;
      chk("pos",        i, int'(pos_a),              vecs[i].pos);
      chk("sensors",    i, int'({f1_a, f2_a, f3_a}), int'(vecs[i].f));
      chk("floor_code", i, int'(code_a),             int'(vecs[i].code));
      chk("moving",     i, int'(mv_a),               int'(vecs[i].mv));
      chk("conflict",   i, int'(cf_a),               int'(vecs[i].cf));
      chk("overtravel", i, int'(ot_a),               int'(vecs[i].ot));
    end
    reset_a = 1'b0; mup_a = 1'b0; mdw_a = 1'b0;

    // Fast-step instance: idle at floor 3 after the initial reset
    chk("b_pos_start", 0, int'(pos_b), 8);
    chk("b_sensors_start", 0, int'({f1_b, f2_b, f3_b}), 3'b001);
    chk("b_code_start", 0, int'(code_b), 3);

    // Steps on the very first cycle of a new command
    mdw_b = 1'b1;
    @(posedge clk); #1;
    chk("b_pos_first_down", 1, int'(pos_b), 7);
    chk("b_code_between", 1, int'(code_b), 0);
    repeat (3) @(posedge clk); #1;
    chk("b_pos_floor2", 2, int'(pos_b), 4);
    chk("b_sensors_floor2", 2, int'({f1_b, f2_b, f3_b}), 3'b010);

    mdw_b = 1'b0; mup_b = 1'b1;
    @(posedge clk); #1;
    chk("b_pos_first_up", 3, int'(pos_b), 5);
    repeat (3) @(posedge clk); #1;
    chk("b_pos_top", 4, int'(pos_b), 8);
    chk("b_ot_at_top", 4, int'(ot_b), 0);
    @(posedge clk); #1;
    chk("b_pos_held", 5, int'(pos_b), 8);
    chk("b_ot_set", 5, int'(ot_b), 1);

    // Reset while commanding down from the top
    mup_b = 1'b0; mdw_b = 1'b1; reset_b = 1'b1;
    @(posedge clk); #1;
    reset_b = 1'b0;
    chk("b_pos_after_reset", 6, int'(pos_b), 8);
    chk("b_ot_after_reset", 6, int'(ot_b), 0);
    chk("b_f3_after_reset", 6, int'(f3_b), 1);
    mdw_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_elevador_planta_3pisos
`default_nettype wire
